// File: rtl/lut_layer_sequencer_if.sv
// Stream interface of lut_layer_sequencer: layer input vector in, packed neuron outputs out.
// master = surrounding pipeline, slave = the sequencer.
interface lut_layer_sequencer_if #(
  parameter int IN_BITS     = 128,
  parameter int NUM_NEURONS = 128
);
  logic                   in_valid;
  logic                   in_ready;
  logic [IN_BITS-1:0]     in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one shared, run-time configurable LUT store
// evaluated one neuron per cycle into a packed output vector.
module lut_layer_sequencer #(
  parameter  int IN_BITS     = 128,
  parameter  int NUM_NEURONS = 128,
  parameter  int FAN_IN      = 6,
  localparam int IDX_W       = $clog2(IN_BITS),
  localparam int NID_W       = $clog2(NUM_NEURONS),
  localparam int LUT_W       = 2**FAN_IN
) (
  input  logic                      clk,
  input  logic                      rst,
  lut_layer_sequencer_if.slave      stream,
  output logic                      o_busy,
  input  logic                      i_cfg_lut_we,
  input  logic                      i_cfg_conn_we,
  input  logic [NID_W-1:0]          i_cfg_addr,
  input  logic [LUT_W-1:0]          i_cfg_lut_data,
  input  logic [FAN_IN*IDX_W-1:0]   i_cfg_conn_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [NID_W-1:0] LAST_N      = NID_W'(NUM_NEURONS - 1);
  localparam logic [NID_W:0]   NUM_N_EXT   = (NID_W+1)'(NUM_NEURONS);
  localparam logic [IDX_W:0]   IN_BITS_EXT = (IDX_W+1)'(IN_BITS);

  logic [1:0]               r_state;
  logic [IN_BITS-1:0]       r_in_reg;
  logic [NID_W-1:0]         r_n;
  logic                     r_issue;
  logic                     r_v_q;
  logic [NID_W-1:0]         r_n_q;
  logic [FAN_IN-1:0]        r_addr_q;
  logic [NUM_NEURONS-1:0]   r_out_data;

  // Configuration store; deliberately never reset so programming survives rst.
  logic [LUT_W-1:0]         r_lut  [NUM_NEURONS];
  logic [FAN_IN*IDX_W-1:0]  r_conn [NUM_NEURONS];

  logic [FAN_IN*IDX_W-1:0]  w_conn_word;
  logic [FAN_IN-1:0]        w_addr;
  logic [LUT_W-1:0]         w_lut_word;
  logic                     w_lut_bit;
  logic                     w_cfg_ok;

  assign w_conn_word = r_conn[r_n];
  assign w_lut_word  = r_lut[r_n_q];
  assign w_lut_bit   = w_lut_word[r_addr_q];
  assign w_cfg_ok    = (r_state == IDLE) && ({1'b0, i_cfg_addr} < NUM_N_EXT);

  // Out-of-range connectivity indices feed a constant 0 into the LUT address.
  for (genvar g = 0; g < FAN_IN; g++) begin : g_addr
    logic [IDX_W-1:0] w_idx;
    assign w_idx     = w_conn_word[g*IDX_W +: IDX_W];
    assign w_addr[g] = ({1'b0, w_idx} < IN_BITS_EXT) ? r_in_reg[w_idx] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_cfg_ok) begin
      if (i_cfg_lut_we)  r_lut[i_cfg_addr]  <= i_cfg_lut_data;
      if (i_cfg_conn_we) r_conn[i_cfg_addr] <= i_cfg_conn_data;
    end
  end

  // Two-stage pipeline in RUN: issue gathers address of neuron r_n, write stage
  // looks up the LUT one cycle later; the final write moves to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_reg   <= '0;
      r_n        <= '0;
      r_issue    <= 1'b0;
      r_v_q      <= 1'b0;
      r_n_q      <= '0;
      r_addr_q   <= '0;
      r_out_data <= '0;
    end else begin
      r_v_q <= 1'b0;
      case (r_state)
        IDLE: begin
          if (stream.in_valid) begin
            r_in_reg   <= stream.in_data;
            r_n        <= '0;
            r_issue    <= 1'b1;
            r_out_data <= '0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (r_issue) begin
            r_addr_q <= w_addr;
            r_n_q    <= r_n;
            r_v_q    <= 1'b1;
            r_n      <= r_n + NID_W'(1);
            if (r_n == LAST_N) r_issue <= 1'b0;
          end
          if (r_v_q) begin
            r_out_data[r_n_q] <= w_lut_bit;
            if (r_n_q == LAST_N) r_state <= DONE;
          end
        end
        DONE: begin
          if (stream.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stream.in_ready  = (r_state == IDLE);
  assign stream.out_valid = (r_state == DONE);
  assign stream.out_data  = r_out_data;
  assign o_busy           = (r_state != IDLE);

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench for lut_layer_sequencer: randomized runs against a truth-table model.
// dut2 uses a 6-bit input so a 3-bit connectivity field can point past the input vector.
module tb_lut_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy1, busy2;
  logic        cfgLutWe, cfgConnWe;
  logic [1:0]  cfgAddr;
  logic [63:0] cfgLutData;
  logic [17:0] cfgConnData;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mLut  [4];
  logic [17:0] mConn [4];

  always #5 clk = ~clk;

  lut_layer_sequencer_if #(.IN_BITS(8), .NUM_NEURONS(4)) s1 ();
  lut_layer_sequencer_if #(.IN_BITS(6), .NUM_NEURONS(4)) s2 ();

  lut_layer_sequencer #(.IN_BITS(8), .NUM_NEURONS(4), .FAN_IN(6)) dut1 (
    .clk(clk), .rst(rst), .stream(s1), .o_busy(busy1),
    .i_cfg_lut_we(cfgLutWe), .i_cfg_conn_we(cfgConnWe), .i_cfg_addr(cfgAddr),
    .i_cfg_lut_data(cfgLutData), .i_cfg_conn_data(cfgConnData)
  );

  lut_layer_sequencer #(.IN_BITS(6), .NUM_NEURONS(4), .FAN_IN(6)) dut2 (
    .clk(clk), .rst(rst), .stream(s2), .o_busy(busy2),
    .i_cfg_lut_we(cfgLutWe), .i_cfg_conn_we(cfgConnWe), .i_cfg_addr(cfgAddr),
    .i_cfg_lut_data(cfgLutData), .i_cfg_conn_data(cfgConnData)
  );

  function automatic logic [17:0] mk_conn(input int f0, input int f1, input int f2,
                                          input int f3, input int f4, input int f5);
    int f [6];
    logic [17:0] r;
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3; f[4] = f4; f[5] = f5;
    r = '0;
    for (int i = 0; i < 6; i++) r = r | (18'(f[i] & 7) << (3 * i));
    return r;
  endfunction

  // Each neuron: build the address from its selected inputs, then read its truth table.
  function automatic logic [3:0] model_eval(input logic [7:0] inv, input int inBits);
    logic [3:0]  res;
    logic [63:0] table1;
    int          addr, idx;
    res = '0;
    for (int n = 0; n < 4; n++) begin
      addr = 0;
      for (int i = 0; i < 6; i++) begin
        idx = int'((mConn[n] >> (3 * i)) & 18'h7);
        if (idx < inBits && inv[idx]) addr = addr | (1 << i);
      end
      table1 = mLut[n];
      res[n] = table1[addr];
    end
    return res;
  endfunction

  function automatic logic [63:0] rand_lut();
    return {$urandom, $urandom};
  endfunction

  task automatic cfg_write(input int n, input logic lutWe, input logic [63:0] lutData,
                           input logic connWe, input logic [17:0] connData, input bit applied);
    cfgAddr     = 2'(n);
    cfgLutWe    = lutWe;
    cfgLutData  = lutData;
    cfgConnWe   = connWe;
    cfgConnData = connData;
    @(posedge clk);
    @(negedge clk);
    cfgLutWe  = 1'b0;
    cfgConnWe = 1'b0;
    if (applied) begin
      if (lutWe)  mLut[n]  = lutData;
      if (connWe) mConn[n] = connData;
    end
  endtask

  task automatic start_run(input logic [7:0] inv);
    s1.in_valid = 1'b1;
    s1.in_data  = inv;
    @(posedge clk);
    @(negedge clk);
    s1.in_valid = 1'b0;
  endtask

  task automatic finish_run(output logic [3:0] got);
    int waited = 0;
    while (!s1.out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!s1.out_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL run_timeout: out_valid=%0b after %0d cycles, required 1", s1.out_valid, waited);
    end
    got = s1.out_data;
    s1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks += 4;
    if (s1.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b required 1", s1.in_ready); end
    if (s1.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %0b required 0", s1.out_valid); end
    if (s1.out_data !== 4'h0) begin failures++; $display("[TB] FAIL reset_out_data: got %h required 0", s1.out_data); end
    if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b required 0", busy1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_eval();
    logic [3:0] got, exp;
    cfg_write(0, 1'b1, 64'h0000_0000_0000_4000, 1'b1, mk_conn(0, 1, 2, 3, 4, 5), 1'b1);
    for (int n = 1; n < 4; n++)
      cfg_write(n, 1'b1, rand_lut(), 1'b1,
                mk_conn($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)), 1'b1);
    start_run(8'b0000_1110);
    finish_run(got);
    exp = model_eval(8'b0000_1110, 8);
    checks += 2;
    if (got[0] !== 1'b1) begin failures++; $display("[TB] FAIL basic_bit0_hit: got %0b required 1", got[0]); end
    if (got !== exp) begin failures++; $display("[TB] FAIL basic_vec_hit: got %h required %h", got, exp); end
    start_run(8'b0000_1111);
    finish_run(got);
    exp = model_eval(8'b0000_1111, 8);
    checks += 2;
    if (got[0] !== 1'b0) begin failures++; $display("[TB] FAIL basic_bit0_miss: got %0b required 0", got[0]); end
    if (got !== exp) begin failures++; $display("[TB] FAIL basic_vec_miss: got %h required %h", got, exp); end
  endtask

  // Neuron n is written on edge E(n+2); unevaluated bits must read 0 until then.
  task automatic test_latency();
    logic [7:0] inv;
    logic [3:0] exp, mask, got;
    inv = 8'($urandom);
    exp = model_eval(inv, 8);
    start_run(inv);
    checks += 4;
    if (s1.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL lat_in_ready_E0: got %0b required 0", s1.in_ready); end
    if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL lat_busy_E0: got %0b required 1", busy1); end
    if (s1.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_out_valid_E0: got %0b required 0", s1.out_valid); end
    if (s1.out_data !== 4'h0) begin failures++; $display("[TB] FAIL lat_out_data_E0: got %h required 0", s1.out_data); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      mask = 4'((1 << (k - 1)) - 1);
      checks += 3;
      if (s1.out_valid !== (k == 5)) begin failures++; $display("[TB] FAIL lat_out_valid_E%0d: got %0b required %0b", k, s1.out_valid, k == 5); end
      if (s1.out_data !== (exp & mask)) begin failures++; $display("[TB] FAIL lat_partial_E%0d: got %h required %h", k, s1.out_data, exp & mask); end
      if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL lat_busy_E%0d: got %0b required 1", k, busy1); end
    end
    finish_run(got);
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b;
    logic [3:0] expA, expB, got;
    int waited = 0;
    a = 8'($urandom);
    b = ~a;
    expA = model_eval(a, 8);
    expB = model_eval(b, 8);
    s1.in_valid = 1'b1;
    s1.in_data  = a;
    @(posedge clk);
    @(negedge clk);
    while (!s1.out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    s1.in_data = b;
    for (int c = 0; c < 10; c++) begin
      checks += 3;
      if (s1.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_out_valid_%0d: got %0b required 1", c, s1.out_valid); end
      if (s1.out_data !== expA) begin failures++; $display("[TB] FAIL bp_out_data_%0d: got %h required %h", c, s1.out_data, expA); end
      if (s1.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready_%0d: got %0b required 0", c, s1.in_ready); end
      @(negedge clk);
    end
    s1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s1.out_ready = 1'b0;
    checks += 2;
    if (s1.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid: got %0b required 0", s1.out_valid); end
    if (s1.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready: got %0b required 1", s1.in_ready); end
    @(posedge clk);
    @(negedge clk);
    s1.in_valid = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL bp_next_accept: busy got %0b required 1", busy1); end
    finish_run(got);
    checks++;
    if (got !== expB) begin failures++; $display("[TB] FAIL bp_next_result: got %h required %h", got, expB); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] inv;
    logic [3:0] got, exp;
    for (int t = 0; t < 6; t++) begin
      cfg_write($urandom_range(0, 3), 1'b1, rand_lut(), 1'($urandom),
                mk_conn($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)), 1'b1);
      inv = 8'($urandom);
      exp = model_eval(inv, 8);
      start_run(inv);
      finish_run(got);
      checks++;
      if (got !== exp) begin failures++; $display("[TB] FAIL b2b_%0d: in=%h got %h required %h", t, inv, got, exp); end
    end
  endtask

  task automatic test_cfg_lockout();
    logic [7:0] inv;
    logic [3:0] got, exp;
    logic [63:0] newLut2;
    inv = 8'($urandom);
    cfg_write(1, 1'b1, 64'h0, 1'b0, 18'h0, 1'b1);
    start_run(inv);
    cfg_write(1, 1'b1, {64{1'b1}}, 1'b0, 18'h0, 1'b0);
    finish_run(got);
    exp = model_eval(inv, 8);
    checks += 2;
    if (got[1] !== 1'b0) begin failures++; $display("[TB] FAIL lock_run1_bit1: got %0b required 0", got[1]); end
    if (got !== exp) begin failures++; $display("[TB] FAIL lock_run1: got %h required %h", got, exp); end
    start_run(inv);
    finish_run(got);
    checks++;
    if (got !== exp) begin failures++; $display("[TB] FAIL lock_run2: got %h required %h", got, exp); end
    cfg_write(1, 1'b1, {64{1'b1}}, 1'b0, 18'h0, 1'b1);
    start_run(inv);
    finish_run(got);
    checks++;
    if (got[1] !== 1'b1) begin failures++; $display("[TB] FAIL lock_idle_write: got %0b required 1", got[1]); end
    // A write on the acceptance edge belongs to the run it starts.
    newLut2 = ~mLut[2];
    cfgAddr = 2'd2; cfgLutData = newLut2; cfgLutWe = 1'b1;
    start_run(inv);
    cfgLutWe = 1'b0;
    mLut[2] = newLut2;
    exp = model_eval(inv, 8);
    finish_run(got);
    checks++;
    if (got !== exp) begin failures++; $display("[TB] FAIL lock_accept_write: got %h required %h", got, exp); end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] inv;
    logic [3:0] got, exp;
    inv = 8'($urandom);
    exp = model_eval(inv, 8);
    start_run(inv);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (s1.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid: got %0b required 0", s1.out_valid); end
    if (s1.out_data !== 4'h0) begin failures++; $display("[TB] FAIL midrst_out_data: got %h required 0", s1.out_data); end
    if (s1.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_in_ready: got %0b required 1", s1.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run(inv);
    finish_run(got);
    checks++;
    if (got !== exp) begin failures++; $display("[TB] FAIL midrst_rerun: got %h required %h", got, exp); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] lut;
    logic [3:0]  exp, expModel, got;
    int waited = 0;
    for (int n = 0; n < 4; n++) begin
      lut = rand_lut();
      lut[63] = ~lut[62];
      cfg_write(n, 1'b1, lut, 1'b1, mk_conn((n == 3) ? 6 : 7, 1, 2, 3, 4, 5), 1'b1);
      exp[n] = lut[62];
    end
    expModel = model_eval(8'h3F, 6);
    s2.in_valid = 1'b1;
    s2.in_data  = 6'h3F;
    @(posedge clk);
    @(negedge clk);
    s2.in_valid = 1'b0;
    while (!s2.out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    got = s2.out_data;
    checks += 3;
    if (s2.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL oor_timeout: out_valid=%0b required 1", s2.out_valid); end
    if (got !== exp) begin failures++; $display("[TB] FAIL oor_addr62: got %h required %h", got, exp); end
    if (got !== expModel) begin failures++; $display("[TB] FAIL oor_model: got %h required %h", got, expModel); end
    s2.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s2.out_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    cfgLutWe     = 1'b0;
    cfgConnWe    = 1'b0;
    cfgAddr      = '0;
    cfgLutData   = '0;
    cfgConnData  = '0;
    s1.in_valid  = 1'b0;
    s1.in_data   = '0;
    s1.out_ready = 1'b0;
    s2.in_valid  = 1'b0;
    s2.in_data   = '0;
    s2.out_ready = 1'b0;
    test_reset();
    test_basic_eval();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_cfg_lockout();
    test_reset_midrun();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
